// File: rtl/fifo_v4_thresh.sv
// Parametrised synchronous FIFO with any-depth wrap, almost-full/almost-empty
// thresholds, full-range occupancy and same-cycle overflow/underflow strobes.
module fifo_v4_thresh #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter bit FALL_THROUGH = 1'b0,
  parameter int AF_THRESH    = DEPTH - 1,
  parameter int AE_THRESH    = 1,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_bad_depth
    $error("fifo_v4_thresh: DEPTH must be at least 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_v4_thresh: AF_THRESH must be within 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_v4_thresh: AE_THRESH must be within 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_n;
  logic                  count_zero, full, empty, ft_hit, bypass;
  logic                  pop_ok, push_ok, do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_zero = (count == '0);
    full       = (count == CNT_W'(DEPTH));
    ft_hit     = FALL_THROUGH & count_zero & push_i;
    empty      = count_zero & ~ft_hit;
    pop_ok     = pop_i & ~empty;
    push_ok    = push_i & (~full | pop_ok);
    // A fall-through push consumed by a same-cycle pop never touches storage.
    bypass     = ft_hit & pop_ok;
    do_wr      = push_ok & ~bypass;
    do_rd      = pop_ok & ~bypass;
    count_n    = count;
    if (do_wr && !do_rd) begin
      count_n = count + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_n = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_n;
    end
  end

  always_comb begin
    data_o         = ft_hit ? data_i : mem[rd_ptr];
    full_o         = full;
    empty_o        = empty;
    almost_full_o  = (count >= CNT_W'(AF_THRESH));
    almost_empty_o = (count <= CNT_W'(AE_THRESH));
    usage_o        = count;
    // A push discarded by flush is not an overflow.
    overflow_o     = push_i & ~push_ok & ~flush_i;
    underflow_o    = pop_i & empty;
  end

endmodule

// File: tb/tb_fifo_v4_thresh.sv
// Scoreboarded bench for fifo_v4_thresh: registered (A) and fall-through (B)
// instances, both DEPTH=5 x 16 bits with default thresholds.
module tb_fifo_v4_thresh;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_flush, a_push, a_pop;
  logic [15:0] a_data, a_dout;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [2:0]  a_usage;
  logic        b_flush, b_push, b_pop;
  logic [15:0] b_data, b_dout;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0]  b_usage;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fifo_v4_thresh #(.DATA_WIDTH(16), .DEPTH(5), .FALL_THROUGH(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .data_i(a_data),
    .push_i(a_push), .pop_i(a_pop), .data_o(a_dout), .full_o(a_full),
    .empty_o(a_empty), .almost_full_o(a_af), .almost_empty_o(a_ae),
    .usage_o(a_usage), .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  fifo_v4_thresh #(.DATA_WIDTH(16), .DEPTH(5), .FALL_THROUGH(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .data_i(b_data),
    .push_i(b_push), .pop_i(b_pop), .data_o(b_dout), .full_o(b_full),
    .empty_o(b_empty), .almost_full_o(b_af), .almost_empty_o(b_ae),
    .usage_o(b_usage), .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && a_pop && !a_empty) begin
      if (qa.size() == 0) begin
        checks++;
        $display("FAIL a_pop_unexpected: got %h expected no data", a_dout);
      end else begin
        e = qa.pop_front();
        chk("a_pop_data", 32'(a_dout), 32'(e));
      end
    end
    if (!rst && b_pop && !b_empty) begin
      if (qb.size() == 0) begin
        checks++;
        $display("FAIL b_pop_unexpected: got %h expected no data", b_dout);
      end else begin
        e = qb.pop_front();
        chk("b_pop_data", 32'(b_dout), 32'(e));
      end
    end
  end

  initial begin
    a_flush = 0; a_push = 0; a_pop = 1; a_data = '0;
    b_flush = 0; b_push = 0; b_pop = 0; b_data = '0;

    @(negedge clk);
    chk("rst_dout", 32'(a_dout), 32'h0);
    chk("rst_usage", 32'(a_usage), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_ae", 32'(a_ae), 32'd1);
    chk("rst_af", 32'(a_af), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_udf", 32'(a_udf), 32'd1);
    @(posedge clk); #1;
    rst = 0; a_pop = 0;

    for (int i = 1; i <= 5; i++) begin
      a_push = 1; a_data = 16'(i); qa.push_back(16'(i));
      @(negedge clk);
      chk("fill_usage", 32'(a_usage), 32'(i - 1));
      chk("fill_af", 32'(a_af), 32'(i - 1 >= 4));
      chk("fill_ae", 32'(a_ae), 32'(i - 1 <= 1));
      chk("fill_ovf", 32'(a_ovf), 32'd0);
      next();
    end
    a_push = 0;
    @(negedge clk);
    chk("full_full", 32'(a_full), 32'd1);
    chk("full_usage", 32'(a_usage), 32'd5);
    chk("full_af", 32'(a_af), 32'd1);
    chk("full_head", 32'(a_dout), 32'h0001);
    next();

    a_push = 1; a_data = 16'h0006;
    @(negedge clk);
    chk("ovf_strobe", 32'(a_ovf), 32'd1);
    next();
    a_push = 0;
    @(negedge clk);
    chk("ovf_usage", 32'(a_usage), 32'd5);
    next();

    a_push = 1; a_pop = 1; a_data = 16'hAAAA; qa.push_back(16'hAAAA);
    @(negedge clk);
    chk("fullpp_ovf", 32'(a_ovf), 32'd0);
    next();
    a_push = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("fullpp_usage", 32'(a_usage), 32'd5);
      next();
    end
    a_pop = 0;
    @(negedge clk);
    chk("drain_usage", 32'(a_usage), 32'd0);
    chk("drain_empty", 32'(a_empty), 32'd1);
    next();

    a_pop = 1;
    @(negedge clk);
    chk("udf_strobe", 32'(a_udf), 32'd1);
    next();
    a_pop = 0;
    @(negedge clk);
    chk("udf_usage", 32'(a_usage), 32'd0);
    next();

    foreach (qa[i]) qa.delete(i);
    for (int i = 1; i <= 3; i++) begin
      a_push = 1; a_data = 16'(i * 16'h11);
      next();
    end
    a_push = 1; a_flush = 1; a_data = 16'h0044;
    @(negedge clk);
    chk("flush_ovf", 32'(a_ovf), 32'd0);
    chk("flush_pre_usage", 32'(a_usage), 32'd3);
    next();
    a_push = 0; a_flush = 0;
    @(negedge clk);
    chk("flush_usage", 32'(a_usage), 32'd0);
    chk("flush_empty", 32'(a_empty), 32'd1);
    chk("flush_ovf_after", 32'(a_ovf), 32'd0);
    next();
    a_push = 1; a_data = 16'h0055; qa.push_back(16'h0055);
    next();
    a_push = 0; a_pop = 1;
    next();
    a_pop = 0;

    a_push = 1; a_data = 16'h0101; qa.push_back(16'h0101);
    next();
    a_data = 16'h0202; qa.push_back(16'h0202);
    next();
    a_data = 16'h0303;
    #2 rst = 1;
    #1;
    chk("arst_usage", 32'(a_usage), 32'd0);
    chk("arst_empty", 32'(a_empty), 32'd1);
    chk("arst_dout", 32'(a_dout), 32'h0);
    chk("arst_ae", 32'(a_ae), 32'd1);
    next();
    rst = 0; a_push = 0;
    qa.delete();
    a_push = 1; a_data = 16'hBEEF; qa.push_back(16'hBEEF);
    next();
    a_push = 0; a_pop = 1;
    @(negedge clk);
    chk("rt_usage", 32'(a_usage), 32'd1);
    next();
    a_pop = 0;

    b_push = 1; b_pop = 1; b_data = 16'h1234; qb.push_back(16'h1234);
    @(negedge clk);
    chk("ft_dout", 32'(b_dout), 32'h1234);
    chk("ft_empty", 32'(b_empty), 32'd0);
    next();
    b_push = 0; b_pop = 0;
    @(negedge clk);
    chk("ft_usage", 32'(b_usage), 32'd0);
    chk("ft_empty_after", 32'(b_empty), 32'd1);
    next();
    b_push = 1; b_data = 16'h5678; qb.push_back(16'h5678);
    @(negedge clk);
    chk("ft_lat_dout", 32'(b_dout), 32'h5678);
    chk("ft_lat_usage", 32'(b_usage), 32'd0);
    next();
    b_push = 0; b_pop = 1;
    @(negedge clk);
    chk("ft_hold_usage", 32'(b_usage), 32'd1);
    next();
    b_pop = 0;
    @(negedge clk);
    chk("ft_final_usage", 32'(b_usage), 32'd0);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
